// File: rtl/cache_perf_counter_pkg.sv
//==============================================================================
// Module      : cache_perf_counter_pkg
// Description : Shared types and constants for the cache performance counter.
// Revision    : 1.0
//==============================================================================
`default_nettype none

package cache_perf_counter_pkg;

   localparam int c_CNT_W_DEFAULT = 32;
   localparam int c_DROP_W        = 8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // Width for a counter running 0 .. window-1 (never narrower than one bit).
   function automatic int win_width(input int window);
      return (window > 1) ? $clog2(window) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cache_perf_counter_if.sv
//==============================================================================
// Module      : cache_perf_counter_if
// Description : Access/event inputs and snapshot handshake of the counter block.
// Revision    : 1.0
//==============================================================================
`default_nettype none

interface cache_perf_counter_if
   import cache_perf_counter_pkg::*;
#(
   parameter int CNT_W = c_CNT_W_DEFAULT
);

   logic                acc_valid;
   logic                l1_hit;
   logic                l2_hit;
   logic                clear;
   logic                snap_req;
   logic                snap_ready;
   logic                snap_valid;
   logic [CNT_W-1:0]    snap_access;
   logic [CNT_W-1:0]    snap_l1;
   logic [CNT_W-1:0]    snap_l2;
   logic [CNT_W-1:0]    snap_mem;
   logic                snap_auto;
   logic                sat_flag;
   logic                conflict_flag;
   logic [c_DROP_W-1:0] drop_cnt;

   modport master (
      output acc_valid, l1_hit, l2_hit, clear, snap_req, snap_ready,
      input  snap_valid, snap_access, snap_l1, snap_l2, snap_mem,
             snap_auto, sat_flag, conflict_flag, drop_cnt
   );

   modport slave (
      input  acc_valid, l1_hit, l2_hit, clear, snap_req, snap_ready,
      output snap_valid, snap_access, snap_l1, snap_l2, snap_mem,
             snap_auto, sat_flag, conflict_flag, drop_cnt
   );

endinterface

`default_nettype wire

// File: rtl/cache_perf_counter_sat_counter.sv
//==============================================================================
// Module      : sat_counter
// Description : Saturating event counter with clear and saturation pulse.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count_nxt,
   output logic             saturated
);

   localparam logic [WIDTH-1:0] c_MAX     = '1;
   localparam logic [WIDTH-1:0] c_PRE_MAX = c_MAX - 1'b1;

   logic [WIDTH-1:0] r_count;

   // count_nxt already includes this cycle's increment so a same-cycle snapshot sees it.
   assign count_nxt = (inc && (r_count != c_MAX)) ? r_count + 1'b1 : r_count;
   assign saturated = inc && (r_count == c_PRE_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else begin
         r_count <= count_nxt;
      end
   end

endmodule

`default_nettype wire

// File: rtl/cache_perf_counter.sv
//==============================================================================
// Module      : cache_perf_counter
// Description : L1/L2/memory access counters with windowed and manual snapshots.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module cache_perf_counter
   import cache_perf_counter_pkg::*;
#(
   parameter int CNT_W  = c_CNT_W_DEFAULT,
   parameter int WINDOW = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,
   cache_perf_counter_if.slave  bus
);

   localparam logic [c_DROP_W-1:0] c_DROP_MAX = '1;

   logic             w_inc_any, w_inc_l1, w_inc_l2, w_inc_mem;
   logic             w_conflict, w_auto, w_trig, w_clr_live;
   logic             w_sat_acc, w_sat_l1, w_sat_l2, w_sat_mem;
   logic [CNT_W-1:0] w_nxt_acc, w_nxt_l1, w_nxt_l2, w_nxt_mem;

   state_t              r_state;
   logic                r_snap_valid, r_snap_auto;
   logic [CNT_W-1:0]    r_snap_acc, r_snap_l1, r_snap_l2, r_snap_mem;
   logic                r_sat, r_conflict;
   logic [c_DROP_W-1:0] r_drop;

   // clear wins over a same-cycle access, so the access is simply not counted.
   assign w_inc_any  = bus.acc_valid && !bus.clear;
   assign w_inc_l1   = w_inc_any && bus.l1_hit;
   assign w_inc_l2   = w_inc_any && !bus.l1_hit && bus.l2_hit;
   assign w_inc_mem  = w_inc_any && !bus.l1_hit && !bus.l2_hit;
   assign w_conflict = w_inc_any && bus.l1_hit && bus.l2_hit;
   assign w_trig     = bus.snap_req || w_auto;
   assign w_clr_live = bus.clear || w_auto;

   generate
      if (WINDOW > 0) begin : g_window
         localparam int                 c_WIN_W    = win_width(WINDOW);
         localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(WINDOW - 1);
         logic [c_WIN_W-1:0] r_win;

         assign w_auto = w_inc_any && (r_win == c_WIN_LAST);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_win <= '0;
            end else if (bus.clear || w_auto) begin
               r_win <= '0;
            end else if (w_inc_any) begin
               r_win <= r_win + 1'b1;
            end
         end
      end else begin : g_no_window
         assign w_auto = 1'b0;
      end
   endgenerate

   sat_counter #(.WIDTH(CNT_W)) u_cnt_acc (
      .clk(clk), .rst_n(rst_n), .inc(w_inc_any), .clr(w_clr_live),
      .count_nxt(w_nxt_acc), .saturated(w_sat_acc)
   );
   sat_counter #(.WIDTH(CNT_W)) u_cnt_l1 (
      .clk(clk), .rst_n(rst_n), .inc(w_inc_l1), .clr(w_clr_live),
      .count_nxt(w_nxt_l1), .saturated(w_sat_l1)
   );
   sat_counter #(.WIDTH(CNT_W)) u_cnt_l2 (
      .clk(clk), .rst_n(rst_n), .inc(w_inc_l2), .clr(w_clr_live),
      .count_nxt(w_nxt_l2), .saturated(w_sat_l2)
   );
   sat_counter #(.WIDTH(CNT_W)) u_cnt_mem (
      .clk(clk), .rst_n(rst_n), .inc(w_inc_mem), .clr(w_clr_live),
      .count_nxt(w_nxt_mem), .saturated(w_sat_mem)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sat      <= 1'b0;
         r_conflict <= 1'b0;
      end else if (bus.clear) begin
         r_sat      <= 1'b0;
         r_conflict <= 1'b0;
      end else begin
         r_sat      <= r_sat || w_sat_acc || w_sat_l1 || w_sat_l2 || w_sat_mem;
         r_conflict <= r_conflict || w_conflict;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_snap_valid <= 1'b0;
         r_snap_auto  <= 1'b0;
         r_snap_acc   <= '0;
         r_snap_l1    <= '0;
         r_snap_l2    <= '0;
         r_snap_mem   <= '0;
         r_drop       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_trig) begin
                  r_state      <= ST_HOLD;
                  r_snap_valid <= 1'b1;
                  r_snap_auto  <= w_auto;
                  r_snap_acc   <= w_nxt_acc;
                  r_snap_l1    <= w_nxt_l1;
                  r_snap_l2    <= w_nxt_l2;
                  r_snap_mem   <= w_nxt_mem;
               end
            end
            ST_HOLD: begin
               if (bus.snap_ready) begin
                  r_state      <= ST_IDLE;
                  r_snap_valid <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         // Any trigger seen while holding is lost, including one in the acceptance cycle.
         if (bus.clear) begin
            r_drop <= '0;
         end else if ((r_state == ST_HOLD) && w_trig && (r_drop != c_DROP_MAX)) begin
            r_drop <= r_drop + 1'b1;
         end
      end
   end

   assign bus.snap_valid    = r_snap_valid;
   assign bus.snap_auto     = r_snap_auto;
   assign bus.snap_access   = r_snap_acc;
   assign bus.snap_l1       = r_snap_l1;
   assign bus.snap_l2       = r_snap_l2;
   assign bus.snap_mem      = r_snap_mem;
   assign bus.sat_flag      = r_sat;
   assign bus.conflict_flag = r_conflict;
   assign bus.drop_cnt      = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_cache_perf_counter.sv
//==============================================================================
// Module      : tb_cache_perf_counter
// Description : Two counter instances (4-bit/no window, 8-bit/window 4) vs a model.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_cache_perf_counter;

   localparam int CW  [2] = '{4, 8};
   localparam int WIN [2] = '{0, 4};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic d_acc = 1'b0, d_l1 = 1'b0, d_l2 = 1'b0, d_clr = 1'b0, d_req = 1'b0, d_rdy = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cache_perf_counter_if #(.CNT_W(4)) if0 ();
   cache_perf_counter_if #(.CNT_W(8)) if1 ();

   assign if0.acc_valid = d_acc;  assign if1.acc_valid = d_acc;
   assign if0.l1_hit    = d_l1;   assign if1.l1_hit    = d_l1;
   assign if0.l2_hit    = d_l2;   assign if1.l2_hit    = d_l2;
   assign if0.clear     = d_clr;  assign if1.clear     = d_clr;
   assign if0.snap_req  = d_req;  assign if1.snap_req  = d_req;
   assign if0.snap_ready = d_rdy; assign if1.snap_ready = d_rdy;

   cache_perf_counter #(.CNT_W(4), .WINDOW(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   cache_perf_counter #(.CNT_W(8), .WINDOW(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   // Model state per instance; counter index 0=access 1=l1 2=l2 3=mem.
   int m_live [2][4];
   int m_snap [2][4];
   int m_win  [2];
   bit m_held [2];
   bit m_sauto[2];
   bit m_sat  [2];
   bit m_conf [2];
   int m_drop [2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 4; k++) begin
            m_live[i][k] = 0;
            m_snap[i][k] = 0;
         end
         m_win[i] = 0; m_held[i] = 0; m_sauto[i] = 0;
         m_sat[i] = 0; m_conf[i] = 0; m_drop[i] = 0;
      end
   endtask

   task automatic model_step(input int i);
      int v[4];
      int mx, idx, k;
      bit auto_t, trig;
      mx     = (1 << CW[i]) - 1;
      v      = m_live[i];
      auto_t = 1'b0;
      if (d_clr) begin
         for (int n = 0; n < 4; n++) v[n] = 0;
         m_win[i] = 0; m_sat[i] = 0; m_conf[i] = 0; m_drop[i] = 0;
      end else if (d_acc) begin
         idx = d_l1 ? 1 : (d_l2 ? 2 : 3);
         for (int n = 0; n < 2; n++) begin
            k = (n == 0) ? 0 : idx;
            if (v[k] < mx) begin
               v[k] = v[k] + 1;
               if (v[k] == mx) m_sat[i] = 1'b1;
            end
         end
         if (d_l1 && d_l2) m_conf[i] = 1'b1;
         if (WIN[i] != 0) begin
            m_win[i] = m_win[i] + 1;
            if (m_win[i] == WIN[i]) begin
               auto_t   = 1'b1;
               m_win[i] = 0;
            end
         end
      end
      trig = d_req || auto_t;
      if (m_held[i]) begin
         if (trig && !d_clr && m_drop[i] < 255) m_drop[i] = m_drop[i] + 1;
         if (d_rdy) m_held[i] = 1'b0;
      end else if (trig) begin
         m_held[i]  = 1'b1;
         m_snap[i]  = v;
         m_sauto[i] = auto_t;
      end
      if (auto_t) begin
         for (int n = 0; n < 4; n++) v[n] = 0;
      end
      m_live[i] = v;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            model_reset();
         end else begin
            model_step(0);
            model_step(1);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_inst(input int i, input logic [63:0] sv, sa, acc, l1, l2, mem,
                             sat, conf, drop);
      chk($sformatf("u%0d.snap_valid", i),    sv,   64'(m_held[i]));
      chk($sformatf("u%0d.snap_auto", i),     sa,   64'(m_sauto[i]));
      chk($sformatf("u%0d.snap_access", i),   acc,  64'(m_snap[i][0]));
      chk($sformatf("u%0d.snap_l1", i),       l1,   64'(m_snap[i][1]));
      chk($sformatf("u%0d.snap_l2", i),       l2,   64'(m_snap[i][2]));
      chk($sformatf("u%0d.snap_mem", i),      mem,  64'(m_snap[i][3]));
      chk($sformatf("u%0d.sat_flag", i),      sat,  64'(m_sat[i]));
      chk($sformatf("u%0d.conflict_flag", i), conf, 64'(m_conf[i]));
      chk($sformatf("u%0d.drop_cnt", i),      drop, 64'(m_drop[i]));
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            check_inst(0, if0.snap_valid, if0.snap_auto, if0.snap_access, if0.snap_l1,
                       if0.snap_l2, if0.snap_mem, if0.sat_flag, if0.conflict_flag, if0.drop_cnt);
            check_inst(1, if1.snap_valid, if1.snap_auto, if1.snap_access, if1.snap_l1,
                       if1.snap_l2, if1.snap_mem, if1.sat_flag, if1.conflict_flag, if1.drop_cnt);
         end
      end
   end

   task automatic step(input bit acc, l1, l2, clr, req, rdy);
      d_acc = acc; d_l1 = l1; d_l2 = l2; d_clr = clr; d_req = req; d_rdy = rdy;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #12;
      chk("reset u0.snap_valid", if0.snap_valid, 0);
      chk("reset u1.snap_valid", if1.snap_valid, 0);
      chk("reset u0.snap_access", if0.snap_access, 0);
      chk("reset u1.snap_auto", if1.snap_auto, 0);
      chk("reset u1.drop_cnt", if1.drop_cnt, 0);
      chk("reset u0.sat_flag", if0.sat_flag, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // L1, L2, miss then manual snapshot
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      chk("man u0.snap_valid", if0.snap_valid, 1);
      chk("man u0.snap_access", if0.snap_access, 3);
      chk("man u0.snap_l1", if0.snap_l1, 1);
      chk("man u0.snap_l2", if0.snap_l2, 1);
      chk("man u0.snap_mem", if0.snap_mem, 1);
      chk("man u0.snap_auto", if0.snap_auto, 0);
      step(0, 0, 0, 0, 0, 1);

      // window of four L1 hits
      step(0, 0, 0, 1, 0, 1);
      for (int n = 0; n < 3; n++) step(1, 1, 0, 0, 0, 1);
      chk("win u1.snap_valid early", if1.snap_valid, 0);
      step(1, 1, 0, 0, 0, 1);
      chk("win u1.snap_valid", if1.snap_valid, 1);
      chk("win u1.snap_access", if1.snap_access, 4);
      chk("win u1.snap_l1", if1.snap_l1, 4);
      chk("win u1.snap_auto", if1.snap_auto, 1);
      step(0, 0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 1, 0);
      chk("delta u1.snap_access", if1.snap_access, 1);
      chk("delta u1.snap_auto", if1.snap_auto, 0);
      chk("delta u0.snap_access", if0.snap_access, 5);

      // triggers while held are dropped
      for (int n = 0; n < 3; n++) step(0, 0, 0, 0, 1, 0);
      chk("drop u1.drop_cnt", if1.drop_cnt, 3);
      chk("drop u1.snap_access", if1.snap_access, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("drop u1.snap_valid released", if1.snap_valid, 0);

      // clear with a same-cycle access while holding
      step(0, 0, 0, 0, 1, 0);
      step(1, 1, 0, 1, 0, 0);
      chk("clr u0.snap_valid", if0.snap_valid, 1);
      chk("clr u0.snap_access", if0.snap_access, 5);
      chk("clr u0.drop_cnt", if0.drop_cnt, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1, 0);
      chk("clr u0.access zeroed", if0.snap_access, 0);
      step(0, 0, 0, 0, 0, 1);

      // saturation of the 4-bit instance
      for (int n = 0; n < 17; n++) step(1, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1, 0);
      chk("sat u0.snap_access", if0.snap_access, 15);
      chk("sat u0.snap_mem", if0.snap_mem, 15);
      chk("sat u0.sat_flag", if0.sat_flag, 1);
      chk("sat u1.snap_access", if1.snap_access, 1);
      step(0, 0, 0, 0, 0, 1);

      // conflicting hit flags, then reset while holding
      step(0, 0, 0, 1, 0, 1);
      chk("clr u0.sat_flag", if0.sat_flag, 0);
      step(1, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      chk("conf u0.snap_l1", if0.snap_l1, 1);
      chk("conf u0.snap_l2", if0.snap_l2, 0);
      chk("conf u0.conflict_flag", if0.conflict_flag, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst u0.snap_valid", if0.snap_valid, 0);
      chk("rst u1.snap_valid", if1.snap_valid, 0);
      chk("rst u0.conflict_flag", if0.conflict_flag, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      step(0, 0, 0, 0, 1, 0);
      chk("post-rst u1.snap_valid", if1.snap_valid, 1);
      chk("post-rst u1.snap_access", if1.snap_access, 0);

      // snap_req coinciding with the window trigger, then a drop in the accept cycle
      step(0, 0, 0, 0, 0, 1);
      for (int n = 0; n < 3; n++) step(1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 1, 0);
      chk("both u1.snap_auto", if1.snap_auto, 1);
      chk("both u1.snap_access", if1.snap_access, 4);
      chk("both u0.snap_auto", if0.snap_auto, 0);
      step(0, 0, 0, 0, 1, 1);
      chk("acc-drop u1.drop_cnt", if1.drop_cnt, 1);
      chk("acc-drop u1.snap_valid", if1.snap_valid, 0);
      step(0, 0, 0, 0, 1, 0);
      chk("zeroed u1.snap_access", if1.snap_access, 0);
      chk("kept u0.snap_access", if0.snap_access, 4);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cache_perf_counter.md
CACHE_PERF_COUNTER -- requirements
Module: cache_perf_counter

Interface
REQ-001 Parameter CNT_W, default 32: width of every event counter.
REQ-002 Parameter WINDOW, default 256: accesses per automatic snapshot; 0 disables auto-snapshot.
REQ-003 clk  in  1: single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1: asynchronous, active-low reset.
REQ-005 acc_valid  in  1: one completed cache access this cycle.
REQ-006 l1_hit  in  1: access hit in L1; qualified by acc_valid.
REQ-007 l2_hit  in  1: access missed L1 and hit L2; qualified by acc_valid.
REQ-008 clear  in  1: zero live counters and window count.
REQ-009 snap_req  in  1: manual snapshot request, single-cycle pulse.
REQ-010 snap_ready  in  1: consumer accepts the held snapshot.
REQ-011 snap_valid  out  1: snapshot registers hold valid data.
REQ-012 snap_access, snap_l1, snap_l2, snap_mem  out  CNT_W each: snapshot of accesses, L1 hits, L2 hits, memory fills.
REQ-013 snap_auto  out  1: held snapshot came from the window trigger, not snap_req.
REQ-014 sat_flag  out  1: sticky; some live counter saturated.
REQ-015 conflict_flag  out  1: sticky; l1_hit and l2_hit both high with acc_valid.
REQ-016 drop_cnt  out  8: triggers lost while a snapshot was held; saturates at 255.

Function
REQ-017 On acc_valid, access count SHALL increment by 1; exactly one of l1/l2/mem SHALL increment: l1 if l1_hit, else l2 if l2_hit, else mem.
REQ-018 l1_hit and l2_hit both high SHALL count as L1 only and set conflict_flag.
REQ-019 Each live counter SHALL saturate at all-ones and hold; the first saturating increment SHALL set sat_flag.
REQ-020 The window counter SHALL count acc_valid cycles; on reaching WINDOW it SHALL raise an auto trigger in that same cycle and return to 0.
REQ-021 States: IDLE (no snapshot held) and HOLD (snap_valid=1); no other states.
REQ-022 IDLE -> HOLD on snap_req or auto trigger; snap_valid SHALL be 1 in the next cycle.
REQ-023 Captured values SHALL include an access presented in the trigger cycle.
REQ-024 An auto trigger SHALL zero the live counters in the capture cycle (delta mode); snap_req SHALL NOT zero them.
REQ-025 With snap_req and auto trigger in the same cycle, one capture SHALL occur, snap_auto=1, and counters SHALL zero.
REQ-026 HOLD -> IDLE on snap_valid && snap_ready; snapshot outputs SHALL remain stable while in HOLD.
REQ-027 A trigger in HOLD SHALL be dropped and SHALL increment drop_cnt; this includes a trigger in the acceptance cycle.
REQ-028 Auto-trigger counter zeroing SHALL still apply when that trigger is dropped.
REQ-029 clear SHALL zero live counters, the window counter, sat_flag, conflict_flag and drop_cnt next cycle.
REQ-030 clear SHALL take priority over a same-cycle access, which is not counted.
REQ-031 clear SHALL NOT affect a held snapshot or the FSM state.
REQ-032 Counting SHALL never stall; acc_valid is accepted every cycle.

Reset
REQ-033 With rst_n low: FSM=IDLE, snap_valid=0, snap_auto=0, all counters and snapshot outputs=0, sat_flag=0, conflict_flag=0, drop_cnt=0.
REQ-034 Reset mid-HOLD SHALL discard the snapshot; the first trigger after reset SHALL capture normally.

Structure
REQ-035 The shared cache package SHALL hold the FSM state enum, the default CNT_W and the drop_cnt width constant.
REQ-036 One sub-module, sat_counter (parameterised width, inc, clr, saturated pulse), SHALL be instantiated per event counter.

Verification
REQ-037 WINDOW=0; 3 accesses (L1, L2, miss), then snap_req -> next cycle snap_valid=1, access=3, l1=1, l2=1, mem=1, snap_auto=0.
REQ-038 WINDOW=4; 4 L1 hits with snap_ready=1 -> snap_valid one cycle after the 4th access, access=4, l1=4, snap_auto=1; a following L1 hit and snap_req -> access=1.
REQ-039 HOLD with snap_ready=0; three snap_req pulses -> drop_cnt=3 and snapshot values unchanged; snap_ready=1 -> IDLE next cycle.
REQ-040 CNT_W=4; 17 accesses -> snap_access=15, sat_flag=1.
REQ-041 clear with acc_valid high in the same cycle -> access counter 0; held snapshot retained.
REQ-042 acc_valid with l1_hit=l2_hit=1 -> l1+1, l2 unchanged, conflict_flag=1; rst_n low during HOLD -> snap_valid=0 immediately.
